motor_drive_ctrl: RTL
=====================

// Module: motor_drive_ctrl
// PURPOSE
//  Switch-commanded H-bridge motor controller for the Basys board PMOD (JA) motor header.
//  Decodes enable, reverse and speed-level switches into a ramped PWM duty for N_CH channels.
//  Reversal is always safe: ramp to zero, dead time, then flip direction.
//  Drives one 7-seg digit: F (forward), b (reverse) or '-' (stopped).
// PARAMETERS
//  N_CH      2     number of motor channels (shared command, per-channel polarity)
//  PWM_W     8     duty/PWM counter width; full scale FS = 2**PWM_W-1
//  LVL_W     3     speed-level field width
//  STEP      40    duty increment per speed level
//  PWM_DIV   4     clk cycles per PWM counter increment (>=1)
//  RAMP_DIV  2000  clk cycles per 1-LSB duty ramp step (>=1)
//  DEAD_CYC  1000  dead-time cycles with both bridge inputs low (>=1)
//  INV_MASK  0     N_CH-bit mask; bit i=1 swaps in_a/in_b of channel i (mirrored motor)
// PORTS
//  clk    in   1        system clock
//  rst    in   1        synchronous, active-high reset
//  sw     in   LVL_W+2  sw[0]=enable, sw[1]=reverse, sw[LVL_W+1:2]=speed level (async)
//  en     out  N_CH     PWM enable per bridge (JA)
//  in_a   out  N_CH     bridge input A per channel
//  in_b   out  N_CH     bridge input B per channel
//  seg    out  8        7-seg {dp,g,f,e,d,c,b,a}, active low
//  duty   out  PWM_W    current (ramped) duty
//  dir    out  1        applied direction, 1=reverse
//  state  out  2        FSM state code
// BEHAVIOUR
//  Reset: en=0, in_a=0, in_b=0, duty=0, dir=0, state=IDLE, seg=8'hBF, sync flops=0.
//  sw passes a 2-flop synchronizer; all decode uses synced value (2-cycle input latency).
//  Target: tgt = !sw[0] ? 0 : min(lvl*STEP, FS), computed in PWM_W+LVL_W bits, then saturated.
//    Defaults: lvl 0..7 -> 0,40,80,...,240,255.
//  Ramp: every RAMP_DIV cycles duty moves 1 LSB toward ramp goal; never overshoots; no wrap.
//  PWM: counter cnt runs 0..FS-1, advances every PWM_DIV clk; pwm = (cnt < duty).
//    duty=0 -> always low; duty=FS -> always high.
//  en[i] = pwm in RUN/RAMP_DN, 0 in IDLE/DEAD.
//  in_a[i] = ~dir^INV[i], in_b[i] = dir^INV[i] in RUN/RAMP_DN; both 0 in IDLE/DEAD.
//  FSM (2'b00 IDLE, 01 RUN, 10 RAMP_DN, 11 DEAD):
//    IDLE:    duty=0. sw[0]=1 & tgt>0 -> dir<=sw[1], RUN.
//    RUN:     ramp goal = tgt. sw[1]!=dir -> RAMP_DN.
//             duty==0 & tgt==0 -> IDLE.
//    RAMP_DN: ramp goal = 0, ignores tgt. duty==0 -> DEAD, load dead counter.
//    DEAD:    counts DEAD_CYC cycles; then dir<=sw[1] (resampled).
//             If tgt>0 -> RUN, else -> IDLE.
//  Reverse toggled back during RAMP_DN still completes ramp + dead time (no shortcut).
//  Disable during RUN just ramps down in RUN (goal 0), then goes to IDLE; no dead time.
//  Level change in RUN ramps up/down without state change; simultaneous reverse wins.
//  seg: IDLE/DEAD -> 8'hBF ('-'); otherwise dir=0 -> 8'h8E ('F'), dir=1 -> 8'h83 ('b').
//  Prescaler/ramp/dead counters restart on rst; rst mid-ramp forces outputs off next edge.
// STRUCTURE
//  Package motor_pkg: state enum, SEG_F/SEG_B/SEG_DASH constants, FS/width localparams.
//  Sub-module pwm_gen (PWM_W, PWM_DIV): prescaler + counter + compare, one per design.
//    Shared by all channels; the FSM and ramp stay in the top.
// TESTING (PWM_DIV=1, RAMP_DIV=1, DEAD_CYC=4, N_CH=2, INV_MASK=2'b10)
//  rst held 3 cycles with sw=all 1 -> en=0, in_a=in_b=0, duty=0, seg=8'hBF throughout.
//  sw=5'b01101 (en, fwd, lvl3) -> RUN; duty rises 1/cycle to 120, holds.
//    in_a=2'b01, in_b=2'b10; seg=8'h8E.
//  At duty=120 set sw[1]=1 -> RAMP_DN, duty falls to 0, DEAD for 4 cycles with en=in_a=in_b=0.
//    Then RUN, dir=1, seg=8'h83, duty ramps to 120.
//  lvl=7 -> duty saturates at 255; en constantly high across 2 PWM periods.
//    lvl=0 -> ramps to 0, then IDLE, seg=8'hBF.
//  lvl=1 (duty 40) steady -> en high exactly 40 of every 255 cycles per channel.
//  Assert rst mid-ramp (duty=60) -> next edge all outputs reset. Release with en=1 -> ramp from 0.

Source files
------------

// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// motor_pkg : shared types and constants for the H-bridge motor controller
// Revision  : 1.0
// ============================================================================
package motor_pkg;

    localparam int ST_W  = 2;
    localparam int SEG_W = 8;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE    = 2'b00,
        ST_RUN     = 2'b01,
        ST_RAMP_DN = 2'b10,
        ST_DEAD    = 2'b11
    } state_t;

    // 7-seg patterns {dp,g,f,e,d,c,b,a}, active low
    localparam logic [SEG_W-1:0] SEG_F    = 8'h8E;
    localparam logic [SEG_W-1:0] SEG_B    = 8'h83;
    localparam logic [SEG_W-1:0] SEG_DASH = 8'hBF;

    function automatic logic [SEG_W-1:0] seg_code(input state_t s, input logic d);
        if (s == ST_IDLE || s == ST_DEAD) return SEG_DASH;
        return d ? SEG_B : SEG_F;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_gen.sv
`default_nettype none
// ============================================================================
// pwm_gen : prescaled free-running PWM counter with duty compare
// Revision : 1.0
// ============================================================================
module pwm_gen #(
    parameter int PWM_W   = 8,
    parameter int PWM_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty,
    output logic             pwm
);

    localparam int PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    // Counter stops at FS-1 so duty=FS gives a constant high output
    localparam logic [PWM_W-1:0] CNT_LAST = PWM_W'((2**PWM_W) - 2);

    logic [PRE_W-1:0] r_pre;
    logic [PWM_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = (r_pre == PRE_W'(PWM_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
            if (w_tick) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + PWM_W'(1);
            end
        end
    end

    assign pwm = (r_cnt < duty);

endmodule
`default_nettype wire

// File: rtl/motor_drive_ctrl.sv
`default_nettype none
// ============================================================================
// motor_drive_ctrl : switch-commanded ramped-PWM H-bridge controller with safe reversal
// Revision         : 1.0
// ============================================================================
module motor_drive_ctrl
    import motor_pkg::*;
#(
    parameter int              N_CH     = 2,
    parameter int              PWM_W    = 8,
    parameter int              LVL_W    = 3,
    parameter int              STEP     = 40,
    parameter int              PWM_DIV  = 4,
    parameter int              RAMP_DIV = 2000,
    parameter int              DEAD_CYC = 1000,
    parameter logic [N_CH-1:0] INV_MASK = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LVL_W+1:0] sw,
    output logic [N_CH-1:0]  en,
    output logic [N_CH-1:0]  in_a,
    output logic [N_CH-1:0]  in_b,
    output logic [SEG_W-1:0] seg,
    output logic [PWM_W-1:0] duty,
    output logic             dir,
    output logic [ST_W-1:0]  state
);

    localparam int FS     = (2**PWM_W) - 1;
    localparam int PW     = PWM_W + LVL_W;
    localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int DEAD_W = $clog2(DEAD_CYC + 1);

    logic [LVL_W+1:0]  r_sw_meta;
    logic [LVL_W+1:0]  r_sw_sync;
    logic              w_sw_en;
    logic              w_sw_rev;
    logic [PW-1:0]     w_prod;
    logic [PWM_W-1:0]  w_tgt;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_dir;
    logic              w_dir_nxt;
    logic [DEAD_W-1:0] r_dead;
    logic [DEAD_W-1:0] w_dead_nxt;
    logic [PWM_W-1:0]  r_duty;
    logic [PWM_W-1:0]  w_goal;
    logic [RAMP_W-1:0] r_ramp;
    logic              w_ramp_tick;
    logic              w_active;
    logic              w_pwm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta <= '0;
            r_sw_sync <= '0;
        end else begin
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
        end
    end

    assign w_sw_en  = r_sw_sync[0];
    assign w_sw_rev = r_sw_sync[1];
    assign w_prod   = PW'(r_sw_sync[LVL_W+1:2]) * PW'(STEP);
    assign w_tgt    = !w_sw_en         ? '0 :
                      (w_prod > PW'(FS)) ? PWM_W'(FS) : w_prod[PWM_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_dir   <= 1'b0;
            r_dead  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dir   <= w_dir_nxt;
            r_dead  <= w_dead_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_dir_nxt   = r_dir;
        w_dead_nxt  = r_dead;
        w_goal      = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_sw_en && (w_tgt != '0)) begin
                    w_dir_nxt   = w_sw_rev;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_goal = w_tgt;
                // Reversal takes priority over any simultaneous level change
                if (w_sw_rev != r_dir) begin
                    w_state_nxt = ST_RAMP_DN;
                end else if ((r_duty == '0) && (w_tgt == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RAMP_DN: begin
                if (r_duty == '0) begin
                    w_dead_nxt  = DEAD_W'(DEAD_CYC - 1);
                    w_state_nxt = ST_DEAD;
                end
            end
            ST_DEAD: begin
                if (r_dead == '0) begin
                    w_dir_nxt   = w_sw_rev;
                    w_state_nxt = (w_tgt != '0) ? ST_RUN : ST_IDLE;
                end else begin
                    w_dead_nxt = r_dead - DEAD_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_ramp_tick = (r_ramp == RAMP_W'(RAMP_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ramp <= '0;
            r_duty <= '0;
        end else begin
            r_ramp <= w_ramp_tick ? '0 : r_ramp + RAMP_W'(1);
            if (r_state == ST_IDLE) begin
                r_duty <= '0;
            end else if (w_ramp_tick) begin
                if (r_duty < w_goal) begin
                    r_duty <= r_duty + PWM_W'(1);
                end else if (r_duty > w_goal) begin
                    r_duty <= r_duty - PWM_W'(1);
                end
            end
        end
    end

    pwm_gen #(
        .PWM_W   (PWM_W),
        .PWM_DIV (PWM_DIV)
    ) u_pwm_gen (
        .clk  (clk),
        .rst  (rst),
        .duty (r_duty),
        .pwm  (w_pwm)
    );

    assign w_active = (r_state == ST_RUN) || (r_state == ST_RAMP_DN);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign en[i]   = w_active & w_pwm;
        assign in_a[i] = w_active & (~r_dir ^ INV_MASK[i]);
        assign in_b[i] = w_active & ( r_dir ^ INV_MASK[i]);
    end

    assign seg   = seg_code(r_state, r_dir);
    assign duty  = r_duty;
    assign dir   = r_dir;
    assign state = r_state;

endmodule
`default_nettype wire
